// File: rtl/dram_line_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_line_cache_pkg
// Description : Shared constants for the DRAM line cache. This package holds
//               the controller state encodings, the line geometry and a
//               helper that derives the tag width from the address split.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_line_cache_pkg;

    // Line geometry: 16-byte lines give 4 offset bits.
    localparam int c_line_bytes = 16;
    localparam int c_offset_w   = 4;
    localparam int c_line_w     = 8 * c_line_bytes;

    // Controller states
    localparam int         c_state_w  = 3;
    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_lookup   = 3'd1;
    localparam logic [2:0] c_rd_req   = 3'd2;
    localparam logic [2:0] c_rd_guard = 3'd3;
    localparam logic [2:0] c_rd_wait  = 3'd4;
    localparam logic [2:0] c_wr_req   = 3'd5;
    localparam logic [2:0] c_wr_guard = 3'd6;
    localparam logic [2:0] c_wr_wait  = 3'd7;

    // Tag covers addr[addr_msb : line_num_width + offset bits].
    function automatic int tag_width(input int addr_msb, input int line_num_width);
        return addr_msb - line_num_width - c_offset_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_line_cache_ram.sv
`default_nettype none
// ============================================================================
// Module      : dram_line_cache_ram
// Description : Tag and line storage for the DRAM line cache. Asynchronous
//               (combinational) read by index, one synchronous write port
//               with a per-byte enable on the 128-bit line. Each byte lane
//               is its own small array so the tools map it to distributed
//               RAM.
// Ports       : i_clk       - clock
//               i_rd_index  - read index
//               o_rd_tag    - tag stored at i_rd_index
//               o_rd_line   - line stored at i_rd_index
//               i_wr_en     - write strobe (tag written on every strobe)
//               i_wr_index  - write index
//               i_wr_tag    - tag to store
//               i_wr_line   - line data to store
//               i_wr_be     - byte enables for the line, bit n = byte n
// Revision    : 1.0 - initial release
// ============================================================================
module dram_line_cache_ram
    import dram_line_cache_pkg::*;
#(
    parameter int LINE_NUM_WIDTH = 7,
    parameter int TAG_WIDTH      = 16
) (
    input  logic                      i_clk,
    input  logic [LINE_NUM_WIDTH-1:0] i_rd_index,
    output logic [TAG_WIDTH-1:0]      o_rd_tag,
    output logic [c_line_w-1:0]       o_rd_line,
    input  logic                      i_wr_en,
    input  logic [LINE_NUM_WIDTH-1:0] i_wr_index,
    input  logic [TAG_WIDTH-1:0]      i_wr_tag,
    input  logic [c_line_w-1:0]       i_wr_line,
    input  logic [c_line_bytes-1:0]   i_wr_be
);

    localparam int c_depth = 1 << LINE_NUM_WIDTH;

    logic [TAG_WIDTH-1:0] r_tag_mem [c_depth];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_wr_index] <= i_wr_tag;
        end
    end

    assign o_rd_tag = r_tag_mem[i_rd_index];

    generate
        for (genvar b = 0; b < c_line_bytes; b++) begin : g_byte_lane
            logic [7:0] r_lane_mem [c_depth];

            always_ff @(posedge i_clk) begin
                if (i_wr_en && i_wr_be[b]) begin
                    r_lane_mem[i_wr_index] <= i_wr_line[8*b +: 8];
                end
            end

            assign o_rd_line[8*b +: 8] = r_lane_mem[i_rd_index];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dram_line_cache.sv
`default_nettype none
// ============================================================================
// Module      : dram_line_cache
// Description : Direct-mapped, write-through, no-write-allocate line cache
//               sitting between the core memory port and the DRAM controller
//               wrapper. Reads are served as 32-bit words out of 16-byte
//               lines; misses fetch a full line. Every write goes to DRAM and
//               also patches the cached line when it hits.
// Ports       : i_clk, i_rst_x          - clock, async active-low reset
//               i_rd_en, i_wr_en        - core request pulses (only when idle)
//               i_addr, i_data, i_mask  - byte address, write data, byte mask
//                                         (mask bit 1 = byte not written)
//               i_flush                 - invalidate all lines (idle only)
//               o_data, o_busy          - read data, request in progress
//               o_dram_rd_en/wr_en      - registered pulses to the wrapper
//               o_dram_addr/data/mask   - registered wrapper request fields
//               i_dram_data, i_dram_busy- wrapper line data and busy
// Revision    : 1.0 - initial release
// ============================================================================
module dram_line_cache
    import dram_line_cache_pkg::*;
#(
    parameter int LINE_NUM_WIDTH = 7,
    parameter int DRAM_ADDR_MSB  = 26
) (
    input  logic                i_clk,
    input  logic                i_rst_x,
    input  logic                i_rd_en,
    input  logic                i_wr_en,
    input  logic [31:0]         i_addr,
    input  logic [31:0]         i_data,
    input  logic [3:0]          i_mask,
    input  logic                i_flush,
    output logic [31:0]         o_data,
    output logic                o_busy,
    output logic                o_dram_rd_en,
    output logic                o_dram_wr_en,
    output logic [31:0]         o_dram_addr,
    output logic [31:0]         o_dram_data,
    output logic [3:0]          o_dram_mask,
    input  logic [c_line_w-1:0] i_dram_data,
    input  logic                i_dram_busy
);

    localparam int c_tag_w = tag_width(DRAM_ADDR_MSB, LINE_NUM_WIDTH);
    localparam int c_depth = 1 << LINE_NUM_WIDTH;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_state_w-1:0] r_state;
    logic [31:2]          r_addr;     // byte lane bits are never needed
    logic [31:0]          r_data;
    logic [3:0]           r_mask;
    logic                 r_is_wr;
    logic [c_depth-1:0]   r_valid;
    logic [31:0]          r_o_data;
    logic                 r_busy;
    logic                 r_dram_rd_en;
    logic                 r_dram_wr_en;
    logic [31:0]          r_dram_addr;
    logic [31:0]          r_dram_data;
    logic [3:0]           r_dram_mask;

    // ------------------------------------------------------------------
    // Address split of the latched request
    // ------------------------------------------------------------------
    logic [1:0]                w_word;
    logic [LINE_NUM_WIDTH-1:0] w_index;
    logic [c_tag_w-1:0]        w_tag;
    logic [c_tag_w-1:0]        w_ram_tag;
    logic [c_line_w-1:0]       w_ram_line;
    logic                      w_hit;
    logic                      w_unused;

    assign w_word  = r_addr[3:2];
    assign w_index = r_addr[LINE_NUM_WIDTH+3:4];
    assign w_tag   = r_addr[DRAM_ADDR_MSB:LINE_NUM_WIDTH+4];
    assign w_hit   = r_valid[w_index] && (w_ram_tag == w_tag);

    // Word-aligned accesses only; the byte lane bits carry no meaning.
    assign w_unused = ^i_addr[1:0];

    // ------------------------------------------------------------------
    // Next state and array write control
    // ------------------------------------------------------------------
    logic [c_state_w-1:0]    w_next_state;
    logic                    w_ram_we;
    logic [c_line_bytes-1:0] w_ram_be;
    logic [c_line_w-1:0]     w_ram_wline;

    always_comb begin
        w_next_state = r_state;
        w_ram_we     = 1'b0;
        w_ram_be     = '0;
        w_ram_wline  = {4{r_data}};
        case (r_state)
            c_idle: begin
                if (i_wr_en || i_rd_en) begin
                    w_next_state = c_lookup;
                end
            end
            c_lookup: begin
                if (r_is_wr) begin
                    w_next_state = c_wr_req;
                    // Write hit patches only the unmasked bytes of the word;
                    // an all-ones mask leaves the line untouched.
                    if (w_hit) begin
                        w_ram_we = 1'b1;
                        w_ram_be = c_line_bytes'({12'h000, ~r_mask}) << {w_word, 2'b00};
                    end
                end else begin
                    w_next_state = w_hit ? c_idle : c_rd_req;
                end
            end
            c_rd_req: begin
                if (!i_dram_busy) begin
                    w_next_state = c_rd_guard;
                end
            end
            c_rd_guard: begin
                w_next_state = c_rd_wait;
            end
            c_rd_wait: begin
                if (!i_dram_busy) begin
                    w_next_state = c_idle;
                    w_ram_we     = 1'b1;
                    w_ram_be     = '1;
                    w_ram_wline  = i_dram_data;
                end
            end
            c_wr_req: begin
                if (!i_dram_busy) begin
                    w_next_state = c_wr_guard;
                end
            end
            c_wr_guard: begin
                w_next_state = c_wr_wait;
            end
            c_wr_wait: begin
                if (!i_dram_busy) begin
                    w_next_state = c_idle;
                end
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tag / line storage
    // ------------------------------------------------------------------
    dram_line_cache_ram #(
        .LINE_NUM_WIDTH (LINE_NUM_WIDTH),
        .TAG_WIDTH      (c_tag_w)
    ) u_ram (
        .i_clk      (i_clk),
        .i_rd_index (w_index),
        .o_rd_tag   (w_ram_tag),
        .o_rd_line  (w_ram_line),
        .i_wr_en    (w_ram_we),
        .i_wr_index (w_index),
        .i_wr_tag   (w_tag),
        .i_wr_line  (w_ram_wline),
        .i_wr_be    (w_ram_be)
    );

    // ------------------------------------------------------------------
    // State, valid bits and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            r_state      <= c_idle;
            r_addr       <= '0;
            r_data       <= '0;
            r_mask       <= '0;
            r_is_wr      <= 1'b0;
            r_valid      <= '0;
            r_o_data     <= '0;
            r_busy       <= 1'b0;
            r_dram_rd_en <= 1'b0;
            r_dram_wr_en <= 1'b0;
            r_dram_addr  <= '0;
            r_dram_data  <= '0;
            r_dram_mask  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_busy       <= (w_next_state != c_idle);
            r_dram_rd_en <= 1'b0;
            r_dram_wr_en <= 1'b0;
            case (r_state)
                c_idle: begin
                    // Flush clears valids in the same cycle a request is
                    // latched, so that request looks up a cold cache.
                    if (i_flush) begin
                        r_valid <= '0;
                    end
                    if (i_wr_en || i_rd_en) begin
                        r_addr  <= i_addr[31:2];
                        r_data  <= i_data;
                        r_mask  <= i_mask;
                        r_is_wr <= i_wr_en;
                    end
                end
                c_lookup: begin
                    if (!r_is_wr && w_hit) begin
                        r_o_data <= w_ram_line[32*w_word +: 32];
                    end
                end
                c_rd_req: begin
                    if (!i_dram_busy) begin
                        r_dram_rd_en <= 1'b1;
                        r_dram_addr  <= {r_addr[31:4], 4'h0};
                    end
                end
                c_rd_wait: begin
                    if (!i_dram_busy) begin
                        r_valid[w_index] <= 1'b1;
                        r_o_data         <= i_dram_data[32*w_word +: 32];
                    end
                end
                c_wr_req: begin
                    if (!i_dram_busy) begin
                        r_dram_wr_en <= 1'b1;
                        r_dram_addr  <= {r_addr, 2'b00};
                        r_dram_data  <= r_data;
                        r_dram_mask  <= r_mask;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_data       = r_o_data;
    assign o_busy       = r_busy;
    assign o_dram_rd_en = r_dram_rd_en;
    assign o_dram_wr_en = r_dram_wr_en;
    assign o_dram_addr  = r_dram_addr;
    assign o_dram_data  = r_dram_data;
    assign o_dram_mask  = r_dram_mask;

endmodule
`default_nettype wire

// File: tb/tb_dram_line_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_line_cache
// Description : Self-checking bench for dram_line_cache. A small DRAM
//               wrapper model answers line reads and absorbs word writes;
//               expected read words come from that model's memory image and
//               are queued at issue, then compared when o_busy falls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_line_cache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_en = 1'b0;
    logic         wr_en = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  data = '0;
    logic [3:0]   mask = '0;
    logic         flush = 1'b0;
    logic [31:0]  rdata;
    logic         busy;
    logic         dram_rd_en;
    logic         dram_wr_en;
    logic [31:0]  dram_addr;
    logic [31:0]  dram_wdata;
    logic [3:0]   dram_mask;
    logic [127:0] dram_data = '0;
    logic         dram_busy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dram_line_cache #(
        .LINE_NUM_WIDTH (7),
        .DRAM_ADDR_MSB  (26)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_x      (rst_n),
        .i_rd_en      (rd_en),
        .i_wr_en      (wr_en),
        .i_addr       (addr),
        .i_data       (data),
        .i_mask       (mask),
        .i_flush      (flush),
        .o_data       (rdata),
        .o_busy       (busy),
        .o_dram_rd_en (dram_rd_en),
        .o_dram_wr_en (dram_wr_en),
        .o_dram_addr  (dram_addr),
        .o_dram_data  (dram_wdata),
        .o_dram_mask  (dram_mask),
        .i_dram_data  (dram_data),
        .i_dram_busy  (dram_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // DRAM wrapper model (128 MiB space, upper address bits alias)
    // ------------------------------------------------------------------
    logic [127:0] mem [logic [31:0]];

    function automatic logic [31:0] line_key(input logic [31:0] a);
        return a & 32'h07FF_FFF0;
    endfunction

    function automatic logic [127:0] model_line(input logic [31:0] a);
        logic [127:0] ln;
        logic [31:0]  k;
        k = line_key(a);
        if (mem.exists(k)) return mem[k];
        for (int n = 0; n < 4; n++) ln[32*n +: 32] = (k | 32'(n * 4)) ^ 32'hC0DE_0000;
        return ln;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [127:0] ln;
        ln = model_line(a);
        return ln[32*int'(a[3:2]) +: 32];
    endfunction

    int           cyc = 0;
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    int           rd_cyc = 0;
    int           cal_end_cyc = 0;
    int           lat = 0;
    int           cal_cnt = 0;
    int           cal_req = 20;
    logic         pend_rd = 1'b0;
    logic [127:0] pend_line = '0;
    logic [127:0] tmp_line = '0;
    logic [31:0]  last_rd_addr = '0;
    logic [31:0]  last_wr_addr = '0;
    logic [31:0]  last_wr_data = '0;
    logic [3:0]   last_wr_mask = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            lat       = 0;
            pend_rd   = 1'b0;
            cal_cnt   = cal_req;
            dram_busy = (cal_req != 0);
        end else if (dram_rd_en) begin
            rd_cnt++;
            last_rd_addr = dram_addr;
            rd_cyc       = cyc;
            pend_line    = model_line(dram_addr);
            pend_rd      = 1'b1;
            dram_busy    = 1'b1;
            lat          = 5;
        end else if (dram_wr_en) begin
            wr_cnt++;
            last_wr_addr = dram_addr;
            last_wr_data = dram_wdata;
            last_wr_mask = dram_mask;
            tmp_line     = model_line(dram_addr);
            for (int b = 0; b < 4; b++) begin
                if (!dram_mask[b]) tmp_line[32*int'(dram_addr[3:2]) + 8*b +: 8] = dram_wdata[8*b +: 8];
            end
            mem[line_key(dram_addr)] = tmp_line;
            pend_rd   = 1'b0;
            dram_busy = 1'b1;
            lat       = 3;
        end else if (cal_cnt > 0) begin
            cal_cnt--;
            if (cal_cnt == 0) begin
                dram_busy   = 1'b0;
                cal_end_cyc = cyc;
            end
        end else if (lat > 0) begin
            lat--;
            if (lat == 0) begin
                dram_busy = 1'b0;
                if (pend_rd) dram_data = pend_line;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and request tasks (all called right after a negedge)
    // ------------------------------------------------------------------
    logic [31:0] exp_q [$];

    task automatic wait_idle(input string tag, output int cycles);
        cycles = 0;
        while (busy && cycles < 500) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic fl, input bit exp_miss, input string tag);
        int          rd0;
        int          bcnt;
        logic [31:0] e;
        rd0 = rd_cnt;
        exp_q.push_back(model_word(a));
        rd_en = 1'b1; addr = a; flush = fl;
        @(negedge clk);
        rd_en = 1'b0; flush = 1'b0;
        wait_idle(tag, bcnt);
        e = exp_q.pop_front();
        check({tag, "_data"}, rdata, e);
        check({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), exp_miss ? 32'd1 : 32'd0);
        if (exp_miss) check({tag, "_rd_addr"}, last_rd_addr, {a[31:4], 4'h0});
        else          check({tag, "_hit_busy_cycles"}, 32'(bcnt), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                            input logic also_rd, input string tag);
        int          rd0;
        int          wr0;
        int          bcnt;
        logic [31:0] od;
        rd0 = rd_cnt; wr0 = wr_cnt; od = rdata;
        wr_en = 1'b1; rd_en = also_rd; addr = a; data = d; mask = m;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        wait_idle(tag, bcnt);
        check({tag, "_wr_pulses"}, 32'(wr_cnt - wr0), 32'd1);
        check({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'd0);
        check({tag, "_wr_addr"}, last_wr_addr, {a[31:2], 2'b00});
        check({tag, "_wr_data"}, last_wr_data, d);
        check({tag, "_wr_mask"}, 32'(last_wr_mask), 32'(m));
        check({tag, "_odata_kept"}, rdata, od);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_o_data"}, rdata, 32'h0);
        check({tag, "_o_busy"}, busy, 1'b0);
        check({tag, "_rd_en"}, dram_rd_en, 1'b0);
        check({tag, "_wr_en"}, dram_wr_en, 1'b0);
        check({tag, "_addr"}, dram_addr, 32'h0);
        check({tag, "_wdata"}, dram_wdata, 32'h0);
        check({tag, "_mask"}, 32'(dram_mask), 32'h0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int rd0;
        int g;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        rst_n = 1'b1;

        // Cold read issued while the wrapper is still calibrating
        do_read(32'h0000_1234, 1'b0, 1'b1, "cold");
        check("cold_word_lit", rdata, 32'hC0DE_1234);
        check("cal_order", 32'(rd_cyc > cal_end_cyc), 32'd1);

        do_read(32'h0000_1238, 1'b0, 1'b0, "hit");

        // Partial write hit, then read back the merged word
        do_write(32'h0000_1234, 32'hAABB_CCDD, 4'b0101, 1'b0, "wr_hit");
        do_read(32'h0000_1234, 1'b0, 1'b0, "rd_merged");
        check("merge_lit", rdata, 32'hAADE_CC34);

        // Write miss allocates nothing; next read fetches the written data
        do_write(32'h0000_5000, 32'h1234_5678, 4'b0000, 1'b0, "wr_miss");
        do_read(32'h0000_5000, 1'b0, 1'b1, "rd_after_wmiss");
        check("wmiss_lit", rdata, 32'h1234_5678);

        // Simultaneous rd/wr: write wins; fully masked write leaves line alone
        do_write(32'h0000_1238, 32'hFFFF_FFFF, 4'hF, 1'b1, "wr_prio");
        do_read(32'h0000_1238, 1'b0, 1'b0, "rd_maskf");
        check("maskf_lit", rdata, 32'hC0DE_1238);

        // Flush in the request cycle forces a refetch
        do_read(32'h0000_1234, 1'b1, 1'b1, "flush_rd");

        // Same index, different tag evicts; bits above the tag alias
        do_read(32'h0000_1A34, 1'b0, 1'b1, "conflict");
        do_read(32'h0000_1234, 1'b0, 1'b1, "evicted");
        do_read(32'h8000_1234, 1'b0, 1'b0, "alias_hit");

        // Async reset while waiting for the line
        cal_req = 0;
        rd0 = rd_cnt;
        rd_en = 1'b1; addr = 32'h0000_9000;
        @(negedge clk);
        rd_en = 1'b0;
        g = 0;
        while (rd_cnt == rd0 && g < 200) begin
            g++;
            @(negedge clk);
        end
        check("rst_rd_issued", 32'(rd_cnt - rd0), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("rst_busy_before", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_reset_outs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(32'h0000_9000, 1'b0, 1'b1, "post_rst");
        do_read(32'h0000_1234, 1'b0, 1'b1, "post_rst_cold");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
